wb_trace_checker: RTL and testbench
===================================

WB_TRACE_CHECKER -- requirements
Module: wb_trace_checker

Interface
REQ-001 Parameter DEPTH, default 64: number of expected-value entries.
REQ-002 Parameter HALT_CYCLES, default 8: consecutive unchanged-PC cycles that count as a halt.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on rising edge of Clk.
REQ-005 PC_in  input  32  processor PC, observed every cycle.
REQ-006 WB_Valid  input  1  writeback register write committed this cycle.
REQ-007 WB_WriteData  input  32  committed writeback value; qualified by WB_Valid.
REQ-008 Exp_WrEn  input  1  expected-table write strobe.
REQ-009 Exp_WrAddr  input  6  expected-table write index.
REQ-010 Exp_WrData  input  32  expected-table write value.
REQ-011 Start  input  1  begin a check run.
REQ-012 Exp_Len  input  7  number of expected writebacks, 0..DEPTH; sampled with Start.
REQ-013 Done  output  1  run finished (PASS or FAIL state).
REQ-014 Pass  output  1  run finished, all entries matched.
REQ-015 Fail  output  1  run finished with mismatch or halt.
REQ-016 Halted  output  1  failure cause was halt detection.
REQ-017 MatchCount  output  7  writebacks matched in current run.
REQ-018 FailIndex  output  6  table index where failure occurred.
REQ-019 FailActual  output  32  WB_WriteData captured at mismatch; 0 on halt failure.

Function
REQ-020 States IDLE, RUN, PASS, FAIL; Done=1 exactly in PASS/FAIL; Pass=1 only in PASS; Fail=1 only in FAIL.
REQ-021 Exp_WrEn writes table[Exp_WrAddr] in IDLE, PASS, FAIL; writes in RUN are ignored.
REQ-022 Start in IDLE/PASS/FAIL: next cycle RUN, index=0, MatchCount=0, stall counter=0, FailIndex/FailActual/Halted cleared; Start in RUN ignored.
REQ-023 Start with Exp_Len=0: next state PASS directly; Exp_Len>DEPTH saturated to DEPTH.
REQ-024 RUN, WB_Valid=1, WB_WriteData==table[index]: MatchCount+1, index+1 same edge; if index==len-1, next state PASS.
REQ-025 RUN, WB_Valid=1, mismatch: next state FAIL, FailIndex=index, FailActual=WB_WriteData, MatchCount held.
REQ-026 RUN, WB_Valid=0: no compare, index and MatchCount held.
REQ-027 Stall counter: +1 each RUN cycle PC_in equals previous-cycle PC_in, cleared on any change, saturates at HALT_CYCLES; first RUN cycle always counts as change.
REQ-028 Stall counter reaching HALT_CYCLES in RUN: next state FAIL, Halted=1, FailIndex=index, FailActual=0.
REQ-029 Same-cycle priority: mismatch over halt (Halted=0); final match over halt (PASS).
REQ-030 Compare latency: result visible on outputs one cycle after the WB_Valid edge.
REQ-031 PASS/FAIL sticky; outputs held until Start or Reset; WB_Valid and PC_in ignored outside RUN.

Reset
REQ-032 Reset=1: next edge state IDLE; Done, Pass, Fail, Halted, MatchCount, FailIndex, FailActual, index, stall counter = 0.
REQ-033 Reset has priority over Start, Exp_WrEn and all RUN activity, including mid-run.
REQ-034 Expected table contents are not reset; they survive Reset.

Verification
REQ-035 Load table[0..2]=5,7,12, Start Exp_Len=3, WB_Valid with 5,7,12 on non-consecutive cycles -> Pass=1 one cycle after third, MatchCount=3.
REQ-036 Same table, writebacks 5,9 -> Fail=1, FailIndex=1, FailActual=9, MatchCount=1, Halted=0.
REQ-037 Exp_Len=3, write 5, then PC_in held at 0x20 for 9 cycles -> Fail=1, Halted=1, FailIndex=1, FailActual=0.
REQ-038 Start Exp_Len=0 -> Pass=1 next cycle, MatchCount=0.
REQ-039 Reset asserted mid-run after one match -> all outputs 0, IDLE; new Start with same table and 5,7,12 -> Pass=1 (table retained).
REQ-040 Last expected writeback matches on the cycle stall counter hits HALT_CYCLES -> Pass=1, Halted=0; Exp_WrEn during RUN leaves table unchanged.

Source files
------------

// File: rtl/wb_trace_checker.sv
// rtl/wb_trace_checker.sv - writeback trace checker against a preloaded expected-value table
//
// Compares each committed writeback in a run against a table of expected
// values and flags a mismatch or a stuck PC (halt).
//
// Ports:
//   Clk, Reset           clock, synchronous active-high reset
//   PC_in                processor PC, watched for halt detection during a run
//   WB_Valid/WriteData   committed writeback stream
//   Exp_WrEn/WrAddr/WrData  expected-table write port (ignored while running)
//   Start, Exp_Len       begin a run of Exp_Len expected writebacks
//   Done/Pass/Fail       run outcome, sticky until Start or Reset
//   Halted               failure was caused by a stuck PC
//   MatchCount           writebacks matched so far in this run
//   FailIndex/FailActual table index and observed value at the failure
module wb_trace_checker #(
    parameter int DEPTH       = 64,
    parameter int HALT_CYCLES = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PC_in,
    input  logic        WB_Valid,
    input  logic [31:0] WB_WriteData,
    input  logic        Exp_WrEn,
    input  logic [5:0]  Exp_WrAddr,
    input  logic [31:0] Exp_WrData,
    input  logic        Start,
    input  logic [6:0]  Exp_Len,
    output logic        Done,
    output logic        Pass,
    output logic        Fail,
    output logic        Halted,
    output logic [6:0]  MatchCount,
    output logic [5:0]  FailIndex,
    output logic [31:0] FailActual
);

    localparam int          SW      = $clog2(HALT_CYCLES + 1);
    localparam logic [6:0]  DEPTH_W = 7'(DEPTH);
    localparam logic [SW-1:0] HALT_W = SW'(HALT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL
    } state_t;

    state_t          state_q, state_d;
    logic [6:0]      idx_q, idx_d;
    logic [6:0]      len_q, len_d;
    logic [6:0]      match_q, match_d;
    logic [5:0]      fidx_q, fidx_d;
    logic [31:0]     fact_q, fact_d;
    logic            halted_q, halted_d;
    logic [SW-1:0]   stall_q, stall_d;
    logic            first_q, first_d;
    logic [31:0]     prev_pc_q;

    // Expected table; deliberately not reset so it survives Reset.
    logic [31:0]     exp_mem_q [DEPTH];

    logic [31:0]     exp_word;
    logic            pc_same;
    logic [SW-1:0]   stall_inc;
    logic [6:0]      len_sat;

    assign exp_word  = exp_mem_q[idx_q[5:0]];
    // The first RUN cycle compares against a PC from before the run, so it
    // is always treated as a change.
    assign pc_same   = !first_q && (PC_in == prev_pc_q);
    assign stall_inc = (stall_q == HALT_W) ? HALT_W : stall_q + SW'(1);

    always_ff @(posedge Clk) begin
        if (!Reset && Exp_WrEn && (state_q != S_RUN) && ({1'b0, Exp_WrAddr} < DEPTH_W)) begin
            exp_mem_q[Exp_WrAddr] <= Exp_WrData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            match_q   <= '0;
            fidx_q    <= '0;
            fact_q    <= '0;
            halted_q  <= 1'b0;
            stall_q   <= '0;
            first_q   <= 1'b0;
            prev_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            match_q   <= match_d;
            fidx_q    <= fidx_d;
            fact_q    <= fact_d;
            halted_q  <= halted_d;
            stall_q   <= stall_d;
            first_q   <= first_d;
            prev_pc_q <= PC_in;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        match_d  = match_q;
        fidx_d   = fidx_q;
        fact_d   = fact_q;
        halted_d = halted_q;
        stall_d  = stall_q;
        first_d  = first_q;
        len_sat  = (Exp_Len > DEPTH_W) ? DEPTH_W : Exp_Len;

        case (state_q)
            S_RUN: begin
                first_d = 1'b0;
                stall_d = pc_same ? stall_inc : '0;
                if (WB_Valid) begin
                    if (WB_WriteData == exp_word) begin
                        match_d = match_q + 7'd1;
                        idx_d   = idx_q + 7'd1;
                        if (idx_q == len_q - 7'd1) begin
                            state_d = S_PASS;
                        end
                    end else begin
                        state_d = S_FAIL;
                        fidx_d  = idx_q[5:0];
                        fact_d  = WB_WriteData;
                    end
                end
                // Halt only wins when the writeback did not already end the run.
                if ((state_d == S_RUN) && (stall_d == HALT_W)) begin
                    state_d  = S_FAIL;
                    halted_d = 1'b1;
                    fidx_d   = idx_d[5:0];
                    fact_d   = '0;
                end
            end
            default: begin
                if (Start) begin
                    len_d    = len_sat;
                    idx_d    = '0;
                    match_d  = '0;
                    stall_d  = '0;
                    first_d  = 1'b1;
                    fidx_d   = '0;
                    fact_d   = '0;
                    halted_d = 1'b0;
                    state_d  = (len_sat == 7'd0) ? S_PASS : S_RUN;
                end
            end
        endcase
    end

    assign Done       = (state_q == S_PASS) || (state_q == S_FAIL);
    assign Pass       = (state_q == S_PASS);
    assign Fail       = (state_q == S_FAIL);
    assign Halted     = halted_q;
    assign MatchCount = match_q;
    assign FailIndex  = fidx_q;
    assign FailActual = fact_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
// tb/tb_wb_trace_checker.sv - scoreboard testbench for wb_trace_checker
module tb_wb_trace_checker;

    localparam int H = 8;
    localparam int D = 64;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] PC_in;
    logic        WB_Valid;
    logic [31:0] WB_WriteData;
    logic        Exp_WrEn;
    logic [5:0]  Exp_WrAddr;
    logic [31:0] Exp_WrData;
    logic        Start;
    logic [6:0]  Exp_Len;
    logic        Done, Pass, Fail, Halted;
    logic [6:0]  MatchCount;
    logic [5:0]  FailIndex;
    logic [31:0] FailActual;

    wb_trace_checker #(.DEPTH(D), .HALT_CYCLES(H)) dut (
        .Clk(Clk), .Reset(Reset), .PC_in(PC_in),
        .WB_Valid(WB_Valid), .WB_WriteData(WB_WriteData),
        .Exp_WrEn(Exp_WrEn), .Exp_WrAddr(Exp_WrAddr), .Exp_WrData(Exp_WrData),
        .Start(Start), .Exp_Len(Exp_Len),
        .Done(Done), .Pass(Pass), .Fail(Fail), .Halted(Halted),
        .MatchCount(MatchCount), .FailIndex(FailIndex), .FailActual(FailActual)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit          pass;
        bit          fail;
        bit          halted;
        int          mc;
        int          fidx;
        logic [31:0] fact;
        int          done_at;
    } exp_t;

    exp_t        sbq[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [31:0] mtbl [D];
    bit          s_v[$];
    logic [31:0] s_d[$];
    logic [31:0] s_pc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: walk the run's stimulus cycle by cycle in terms of matched
    // count, PC-hold streak and the rules for which event ends the run.
    function automatic exp_t model(input int len);
        exp_t r;
        int k = 0;
        int stall = 0;
        r = '{pass: 0, fail: 0, halted: 0, mc: 0, fidx: 0, fact: 0, done_at: -1};
        if (len == 0) begin
            r.pass = 1; r.done_at = 0;
            return r;
        end
        for (int c = 0; c < s_v.size(); c++) begin
            if (c > 0 && s_pc[c] == s_pc[c-1]) stall = (stall < H) ? stall + 1 : H;
            else stall = 0;
            if (s_v[c]) begin
                if (s_d[c] == mtbl[k]) begin
                    k++;
                    if (k == len) begin
                        r.pass = 1; r.mc = k; r.done_at = c + 1;
                        return r;
                    end
                end else begin
                    r.fail = 1; r.mc = k; r.fidx = k; r.fact = s_d[c]; r.done_at = c + 1;
                    return r;
                end
            end
            if (stall == H) begin
                r.fail = 1; r.halted = 1; r.mc = k; r.fidx = k; r.fact = 0; r.done_at = c + 1;
                return r;
            end
        end
        return r;
    endfunction

    // Monitor: whenever a run completes, pop the expected outcome and compare.
    initial begin : monitor
        bit   st;
        bit   done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(posedge Clk);
            cyc++;
            st = (Start === 1'b1) && (Reset === 1'b0);
            #1;
            if ((Done === 1'b1) && (st || !done_prev)) begin
                if (sbq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got Done=1 expected no completion (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("done_cycle", cyc, e.done_at);
                    chk("pass", Pass, e.pass);
                    chk("fail", Fail, e.fail);
                    chk("halted", Halted, e.halted);
                    chk("match_count", MatchCount, e.mc);
                    chk("fail_index", FailIndex, e.fidx);
                    chk("fail_actual", FailActual, e.fact);
                end
            end
            done_prev = (Done === 1'b1);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic clr_stim();
        s_v.delete(); s_d.delete(); s_pc.delete();
    endtask

    task automatic push(input bit v, input logic [31:0] d, input logic [31:0] pc);
        s_v.push_back(v); s_d.push_back(d); s_pc.push_back(pc);
    endtask

    task automatic load(input int a, input logic [31:0] d);
        Exp_WrEn = 1'b1; Exp_WrAddr = 6'(a); Exp_WrData = d;
        @(negedge Clk);
        Exp_WrEn = 1'b0;
        mtbl[a] = d;
    endtask

    task automatic do_run(input int len, input bit rand_wr);
        exp_t e;
        int   lsat;
        int   rel;
        lsat = (len > D) ? D : len;
        e = model(lsat);
        rel = e.done_at;
        if (rel < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL run_unterminated: got no end expected an end (len %0d)", len);
            return;
        end
        e.done_at = cyc + 1 + rel;
        sbq.push_back(e);
        Start = 1'b1; Exp_Len = 7'(len);
        @(negedge Clk);
        Start = 1'b0;
        for (int c = 0; c < rel; c++) begin
            WB_Valid = s_v[c]; WB_WriteData = s_d[c]; PC_in = s_pc[c];
            if (rand_wr && $urandom_range(0, 2) == 0) begin
                Exp_WrEn = 1'b1;
                Exp_WrAddr = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 2)) : 6'($urandom_range(0, 63));
                Exp_WrData = $urandom;
            end else begin
                Exp_WrEn = 1'b0;
            end
            @(negedge Clk);
        end
        WB_Valid = 1'b0; Exp_WrEn = 1'b0;
        @(negedge Clk);
    endtask

    task automatic gen_random(input int len);
        int          gk = 0;
        int          n;
        logic [31:0] pc;
        logic [31:0] d;
        bit          v;
        clr_stim();
        pc = $urandom;
        n = len * 3 + 8;
        for (int c = 0; c < n; c++) begin
            if ($urandom_range(0, 99) >= 25) pc = $urandom;
            v = ($urandom_range(0, 1) == 1);
            d = 32'h0;
            if (v) begin
                d = ($urandom_range(0, 49) == 0) ? $urandom : mtbl[gk % D];
                gk++;
            end
            push(v, d, pc);
        end
        // Quiet tail with a frozen PC guarantees the run ends by halt.
        for (int c = 0; c < H + 3; c++) push(1'b0, 32'h0, pc);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_done"}, Done, 0);
        chk({tag, "_pass"}, Pass, 0);
        chk({tag, "_fail"}, Fail, 0);
        chk({tag, "_halted"}, Halted, 0);
        chk({tag, "_mc"}, MatchCount, 0);
        chk({tag, "_fidx"}, FailIndex, 0);
        chk({tag, "_fact"}, FailActual, 0);
    endtask

    initial begin : driver
        int len;
        Reset = 1'b1; PC_in = 0; WB_Valid = 0; WB_WriteData = 0;
        Exp_WrEn = 0; Exp_WrAddr = 0; Exp_WrData = 0; Start = 0; Exp_Len = 0;
        @(negedge Clk);
        @(negedge Clk);
        chk_zero("reset");
        Reset = 1'b0;
        @(negedge Clk);

        load(0, 32'd5); load(1, 32'd7); load(2, 32'd12);

        // Three matches spread over non-consecutive cycles.
        clr_stim();
        push(0, 0, 1); push(1, 5, 2); push(0, 0, 3); push(1, 7, 4);
        push(0, 0, 5); push(0, 0, 6); push(1, 12, 7);
        do_run(3, 0);

        // Mismatch on the second writeback.
        clr_stim();
        push(1, 5, 1); push(0, 0, 2); push(1, 9, 3);
        do_run(3, 0);

        // One match then PC frozen for nine cycles.
        clr_stim();
        push(1, 5, 32'h10);
        for (int i = 0; i < 9; i++) push(0, 0, 32'h20);
        do_run(3, 0);

        // Empty run passes immediately.
        clr_stim();
        do_run(0, 0);

        // Reset beats Start and a table write on the same edge.
        Reset = 1'b1; Start = 1'b1; Exp_Len = 7'd3;
        Exp_WrEn = 1'b1; Exp_WrAddr = 6'd0; Exp_WrData = 32'd99;
        @(negedge Clk);
        Reset = 1'b0; Start = 1'b0; Exp_WrEn = 1'b0;
        chk_zero("rst_start");
        @(negedge Clk);
        chk("rst_start_idle_done", Done, 0);

        // Reset in the middle of a run after one match.
        Start = 1'b1; Exp_Len = 7'd3;
        @(negedge Clk);
        Start = 1'b0; WB_Valid = 1'b1; WB_WriteData = 32'd5; PC_in = 32'd1;
        @(negedge Clk);
        WB_Valid = 1'b0; PC_in = 32'd2;
        chk("midrun_mc", MatchCount, 1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk_zero("midrun_reset");
        @(negedge Clk);
        chk("midrun_idle_done", Done, 0);
        clr_stim();
        push(1, 5, 1); push(1, 7, 2); push(1, 12, 3);
        do_run(3, 0);

        // Final match lands on the same cycle the stall counter saturates,
        // while table writes are attempted throughout the run.
        clr_stim();
        push(1, 5, 1); push(1, 7, 2);
        for (int i = 0; i < 8; i++) push(0, 0, 3);
        push(1, 12, 3);
        do_run(3, 1);
        clr_stim();
        push(1, 5, 1); push(0, 0, 2); push(1, 7, 3); push(1, 12, 4);
        do_run(3, 0);

        // Randomized runs over a random table.
        for (int a = 0; a < D; a++) load(a, (a < 3) ? mtbl[a] : $urandom_range(0, 15));
        for (int r = 0; r < 40; r++) begin
            for (int w = 0; w < 3; w++) load($urandom_range(0, D - 1), $urandom_range(0, 15));
            case ($urandom_range(0, 9))
                0:       len = 0;
                1:       len = $urandom_range(D, 127);
                2:       len = $urandom_range(30, D);
                default: len = $urandom_range(1, 12);
            endcase
            gen_random((len > D) ? D : len);
            do_run(len, 1);
        end

        @(negedge Clk);
        @(negedge Clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
